// File: rtl/regdump_pkg.sv
// Shared types and default widths for the register-file dump engine.
// The CSUM state exists only when REGDUMP_CHECKSUM_EN is defined.
package regdump_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_READ = 3'd1,
      ST_SEND = 3'd2,
`ifdef REGDUMP_CHECKSUM_EN
      ST_CSUM = 3'd3,
`endif
      ST_DONE = 3'd4
   } state_t;

endpackage

// File: rtl/regdump_csum.sv
// Running XOR of accepted dump beats; built only when REGDUMP_CHECKSUM_EN is defined.
`ifdef REGDUMP_CHECKSUM_EN
module regdump_csum #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              en,
   input  logic [DATA_W-1:0] data,
   output logic [DATA_W-1:0] sum
);

   logic [DATA_W-1:0] sum_r;

   // Accumulator: clear wins over a simultaneous enable.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_r <= '0;
      end else if (clear) begin
         sum_r <= '0;
      end else if (en) begin
         sum_r <= sum_r ^ data;
      end else begin
         sum_r <= sum_r;
      end
   end

   assign sum = sum_r;

endmodule
`endif

// File: rtl/regfile_dumper.sv
// Sweeps a register index range through a read port and streams tagged values
// over valid/ready. Optional trailing XOR checksum beat under REGDUMP_CHECKSUM_EN.
module regfile_dumper
   import regdump_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_idx,
   input  logic [ADDR_W-1:0] last_idx,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_idx,
   output logic              out_last
);

   state_t            state_r;
   state_t            next_state_s;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] last_r;
   logic [DATA_W-1:0] out_data_r;
   logic [ADDR_W-1:0] out_idx_r;
   logic              out_last_r;
   logic              busy_r;
   logic              done_r;
   logic              err_r;
   logic              out_valid_r;
   logic              handshake_s;
   logic              at_last_s;

   // abort takes priority, so a beat accepted in the same cycle is dropped
   assign handshake_s = (state_r == ST_SEND) && out_ready && !abort;
   assign at_last_s   = (idx_r == last_r);

`ifdef REGDUMP_CHECKSUM_EN
   logic [DATA_W-1:0] csum_sum_s;

   regdump_csum #(.DATA_W(DATA_W)) u_csum (
      .clk   (clk),
      .reset (reset),
      .clear ((state_r == ST_IDLE) && start),
      .en    (handshake_s),
      .data  (out_data_r),
      .sum   (csum_sum_s)
   );
`endif

   // Next-state selection; abort overrides everything outside IDLE.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (first_idx <= last_idx) begin
                  next_state_s = ST_READ;
               end else begin
                  next_state_s = ST_DONE;
               end
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_READ: next_state_s = ST_SEND;
         ST_SEND: begin
            if (handshake_s) begin
               if (at_last_s) begin
`ifdef REGDUMP_CHECKSUM_EN
                  next_state_s = ST_CSUM;
`else
                  next_state_s = ST_DONE;
`endif
               end else begin
                  next_state_s = ST_READ;
               end
            end else begin
               next_state_s = ST_SEND;
            end
         end
`ifdef REGDUMP_CHECKSUM_EN
         ST_CSUM: begin
            if (out_ready) begin
               next_state_s = ST_DONE;
            end else begin
               next_state_s = ST_CSUM;
            end
         end
`endif
         ST_DONE: next_state_s = ST_IDLE;
         default: next_state_s = ST_IDLE;
      endcase
      if (abort && (state_r != ST_IDLE)) begin
         next_state_s = ST_IDLE;
      end else begin
         next_state_s = next_state_s;
      end
   end

   // State, index counter and registered status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         idx_r       <= '0;
         last_r      <= '0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         busy_r      <= (next_state_s != ST_IDLE);
         done_r      <= (next_state_s == ST_DONE);
         err_r       <= (state_r == ST_IDLE) && (next_state_s == ST_DONE);
`ifdef REGDUMP_CHECKSUM_EN
         out_valid_r <= (next_state_s == ST_SEND) || (next_state_s == ST_CSUM);
`else
         out_valid_r <= (next_state_s == ST_SEND);
`endif
         if ((state_r == ST_IDLE) && start && (first_idx <= last_idx)) begin
            idx_r  <= first_idx;
            last_r <= last_idx;
         end else if (handshake_s && !at_last_s) begin
            idx_r  <= idx_r + ADDR_W'(1);
         end else begin
            idx_r  <= idx_r;
         end
      end
   end

   // Beat payload: captured in READ, swapped for the checksum after the last beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_data_r <= '0;
         out_idx_r  <= '0;
         out_last_r <= 1'b0;
      end else if (state_r == ST_READ) begin
         out_data_r <= rd_data;
         out_idx_r  <= idx_r;
`ifdef REGDUMP_CHECKSUM_EN
         out_last_r <= 1'b0;
`else
         out_last_r <= at_last_s;
`endif
`ifdef REGDUMP_CHECKSUM_EN
      end else if (handshake_s && at_last_s) begin
         out_data_r <= csum_sum_s ^ out_data_r;
         out_idx_r  <= '0;
         out_last_r <= 1'b1;
`endif
      end else begin
         out_data_r <= out_data_r;
         out_idx_r  <= out_idx_r;
         out_last_r <= out_last_r;
      end
   end

   assign busy      = busy_r;
   assign done      = done_r;
   assign err       = err_r;
   assign rd_addr   = idx_r;
   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign out_idx   = out_idx_r;
   assign out_last  = out_last_r;

endmodule

// File: tb/tb_regfile_dumper.sv
// Bench for regfile_dumper: beat-queue model plus directed timing checks.
module tb_regfile_dumper;

   logic        clk = 1'b0;
   logic        reset, start, abort, out_ready;
   logic [4:0]  first_idx, last_idx, rd_addr, out_idx;
   logic [31:0] rd_data, out_data;
   logic        busy, done, err, out_valid, out_last;
   logic [31:0] regs [32];

   typedef struct {
      logic [31:0] d;
      logic [4:0]  i;
      logic        l;
   } beat_t;
   beat_t exp_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int hs_count = 0;

`ifdef REGDUMP_CHECKSUM_EN
   localparam bit CSUM = 1'b1;
`else
   localparam bit CSUM = 1'b0;
`endif

   regfile_dumper dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .first_idx(first_idx), .last_idx(last_idx),
      .busy(busy), .done(done), .err(err),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_idx(out_idx), .out_last(out_last)
   );

   assign rd_data = regs[rd_addr];
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected beat list for a dump, straight from the range and register contents.
   task automatic expect_dump(input int f, input int l);
      logic [31:0] x;
      beat_t b;
      x = 32'h0;
      if (f <= l) begin
         for (int i = f; i <= l; i++) begin
            b.d = regs[i];
            b.i = 5'(i);
            b.l = CSUM ? 1'b0 : (i == l);
            exp_q.push_back(b);
            x = x ^ regs[i];
         end
         if (CSUM) begin
            b.d = x;
            b.i = 5'd0;
            b.l = 1'b1;
            exp_q.push_back(b);
         end
      end
   endtask

   task automatic start_dump(input int f, input int l);
      first_idx = 5'(f);
      last_idx  = 5'(l);
      start     = 1'b1;
      expect_dump(f, l);
      tick();
      start     = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 300 && !seen; c++) begin
         if (done) seen = 1'b1;
         else tick();
      end
      if (!seen) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: done never seen within 300 cycles", name);
      end else begin
         check({name, "_err"}, {31'd0, err}, 32'd0);
         tick();
      end
   endtask

   // Every cycle a beat is offered it must match the head of the expected list.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (exp_q.size() == 0) begin
            check("spurious_valid", {31'd0, out_valid}, 32'd0);
         end else begin
            check("beat_data", out_data, exp_q[0].d);
            check("beat_idx", {27'd0, out_idx}, {27'd0, exp_q[0].i});
            check("beat_last", {31'd0, out_last}, {31'd0, exp_q[0].l});
            if (out_ready && !abort) begin
               void'(exp_q.pop_front());
               hs_count++;
            end
         end
      end
   end

   logic [31:0] c_data [12];
   logic [4:0]  c_idx  [12];
   logic        c_v    [12];
   logic        c_last [12];
   logic        c_done [12];
   logic        c_busy [12];
   int          hs0;
   int          done_cyc;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      first_idx = 5'd0; last_idx = 5'd0;
      for (int i = 0; i < 32; i++) regs[i] = {8'hC0, 3'd0, 5'(i), 16'(i * 1237)};
      regs[1] = 32'h11111111;
      regs[2] = 32'h22222222;
      regs[3] = 32'h33333333;
      tick(); tick();
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_last", {31'd0, out_last}, 32'd0);
      check("rst_data", out_data, 32'd0);
      check("rst_idx", {27'd0, out_idx}, 32'd0);
      check("rst_rdaddr", {27'd0, rd_addr}, 32'd0);
      reset = 1'b0;
      tick();

      // Basic 1..3 dump: beats on cycles 2/4/6, done at 7 (8 with checksum).
      start_dump(1, 3);
      for (int c = 1; c < 12; c++) begin
         c_v[c] = out_valid; c_idx[c] = out_idx; c_data[c] = out_data;
         c_last[c] = out_last; c_done[c] = done; c_busy[c] = busy;
         tick();
      end
      done_cyc = CSUM ? 8 : 7;
      check("t1_c1_valid", {31'd0, c_v[1]}, 32'd0);
      check("t1_c1_busy", {31'd0, c_busy[1]}, 32'd1);
      check("t1_c2_valid", {31'd0, c_v[2]}, 32'd1);
      check("t1_c2_idx", {27'd0, c_idx[2]}, 32'd1);
      check("t1_c2_data", c_data[2], 32'h11111111);
      check("t1_c3_valid", {31'd0, c_v[3]}, 32'd0);
      check("t1_c4_idx", {27'd0, c_idx[4]}, 32'd2);
      check("t1_c4_data", c_data[4], 32'h22222222);
      check("t1_c6_valid", {31'd0, c_v[6]}, 32'd1);
      check("t1_c6_data", c_data[6], 32'h33333333);
      check("t1_c6_last", {31'd0, c_last[6]}, CSUM ? 32'd0 : 32'd1);
      check("t1_c6_done", {31'd0, c_done[6]}, 32'd0);
      check("t1_done", {31'd0, c_done[done_cyc]}, 32'd1);
      check("t1_busy_at_done", {31'd0, c_busy[done_cyc]}, 32'd1);
      check("t1_busy_after", {31'd0, c_busy[done_cyc + 1]}, 32'd0);
      if (CSUM) begin
         check("t1_csum_valid", {31'd0, c_v[7]}, 32'd1);
         check("t1_csum_data", c_data[7], 32'h00000000);
         check("t1_csum_idx", {27'd0, c_idx[7]}, 32'd0);
         check("t1_csum_last", {31'd0, c_last[7]}, 32'd1);
      end
      check("t1_queue_empty", exp_q.size(), 32'd0);

      // Backpressure on beat 2 for five cycles.
      hs0 = hs_count;
      start_dump(1, 3);
      tick(); tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("t2_hold_valid", {31'd0, out_valid}, 32'd1);
         check("t2_hold_idx", {27'd0, out_idx}, 32'd2);
         check("t2_hold_data", out_data, 32'h22222222);
      end
      out_ready = 1'b1;
      wait_done("t2");
      check("t2_queue_empty", exp_q.size(), 32'd0);
      check("t2_beats", 32'(hs_count - hs0), CSUM ? 32'd4 : 32'd3);

      // Inverted range: error pulse, no beats.
      hs0 = hs_count;
      start_dump(5, 2);
      check("t3_done", {31'd0, done}, 32'd1);
      check("t3_err", {31'd0, err}, 32'd1);
      check("t3_valid", {31'd0, out_valid}, 32'd0);
      check("t3_busy", {31'd0, busy}, 32'd1);
      tick();
      check("t3_busy_after", {31'd0, busy}, 32'd0);
      check("t3_done_after", {31'd0, done}, 32'd0);
      check("t3_err_after", {31'd0, err}, 32'd0);
      check("t3_beats", 32'(hs_count - hs0), 32'd0);

      // Abort on the second SEND of 0..31, with out_ready high.
      start_dump(0, 31);
      tick(); tick(); tick();
      check("t4_send2_valid", {31'd0, out_valid}, 32'd1);
      check("t4_send2_idx", {27'd0, out_idx}, 32'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4_valid_after", {31'd0, out_valid}, 32'd0);
      check("t4_busy_after", {31'd0, busy}, 32'd0);
      check("t4_head_kept", {27'd0, exp_q[0].i}, 32'd1);
      exp_q.delete();
      for (int c = 0; c < 4; c++) begin
         check("t4_no_done", {31'd0, done}, 32'd0);
         tick();
      end
      hs0 = hs_count;
      start_dump(31, 31);
      tick();
      check("t4_single_idx", {27'd0, out_idx}, 32'd31);
      check("t4_single_data", out_data, regs[31]);
      wait_done("t4");
      check("t4_beats", 32'(hs_count - hs0), CSUM ? 32'd2 : 32'd1);
      check("t4_queue_empty", exp_q.size(), 32'd0);

      // Reset in the middle of a dump.
      start_dump(0, 31);
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      exp_q.delete();
      check("t5_busy", {31'd0, busy}, 32'd0);
      check("t5_valid", {31'd0, out_valid}, 32'd0);
      check("t5_data", out_data, 32'd0);
      check("t5_idx", {27'd0, out_idx}, 32'd0);
      check("t5_last", {31'd0, out_last}, 32'd0);
      check("t5_rdaddr", {27'd0, rd_addr}, 32'd0);
      hs0 = hs_count;
      start_dump(4, 6);
      check("t5_restart_busy", {31'd0, busy}, 32'd1);
      wait_done("t5");
      check("t5_beats", 32'(hs_count - hs0), CSUM ? 32'd4 : 32'd3);
      check("t5_queue_empty", exp_q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/regfile_dumper.md
# regfile_dumper

Debug read-out engine sitting beside the CPU register file. On a start pulse it sweeps a contiguous register index range through a spare combinational read port and streams each 32-bit value, tagged with its index, over a valid/ready interface. The consumer is the debug/peripheral side, e.g. a UART bridge or the pattern-matching peripheral's capture path. It is the reading counterpart to the core's write-back port.

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width (32 registers)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- start  in  1  begin dump; sampled only in IDLE
- abort  in  1  cancel dump in progress
- first_idx  in  ADDR_W  first register to dump; sampled with start
- last_idx  in  ADDR_W  last register to dump, inclusive; sampled with start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal completion
- err  out  1  one-cycle pulse, coincident with done, when first_idx > last_idx
- rd_addr  out  ADDR_W  register file read address
- rd_data  in  DATA_W  combinational read data for rd_addr
- out_valid  out  1  stream beat valid
- out_ready  in  1  consumer accepts beat
- out_data  out  DATA_W  captured register value, or checksum
- out_idx  out  ADDR_W  register index of the beat
- out_last  out  1  final beat of the dump

## Operation
- States: IDLE, READ, SEND, CSUM (macro only), DONE.
- IDLE:
  - start=1 and first_idx ≤ last_idx: latch both indices, idx←first_idx, go to READ.
  - start=1 and first_idx > last_idx: go to DONE with err flagged; no beats are sent.
- READ: rd_addr=idx; capture rd_data into out_data and idx into out_idx; go to SEND.
- SEND: out_valid=1; out_data, out_idx and out_last are held stable until out_valid && out_ready.
  - On handshake with idx≠last: idx←idx+1, go to READ.
  - On handshake with idx=last: go to CSUM if enabled, otherwise DONE.
- out_last=1 on the idx=last beat when the checksum is disabled.
- DONE: done=1 (err=1 if flagged) for exactly one cycle, then IDLE.
- abort=1 in any busy state: IDLE next cycle, out_valid drops, no done/err pulse. abort has priority over a simultaneous handshake; the beat counts as not delivered.
- start while busy is ignored.
- idx never wraps, because last_idx ≤ 31 bounds the sweep. first=last=31 gives exactly one beat.
- Register writes landing on the same edge as READ capture are not seen; the pre-edge value is captured. There is no snapshot atomicity across the range.
- rd_addr holds the latched idx in all states; its value is don't-care outside READ.

## Timing
- Reset values: busy=0, done=0, err=0, out_valid=0, out_last=0, out_data=0, out_idx=0, rd_addr=0; state=IDLE.
- Latency: start edge → out_valid high 2 cycles later (IDLE→READ→SEND).
- Throughput: one beat per 2 cycles with out_ready held high. Backpressure extends SEND indefinitely.
- Last handshake → done pulse: 1 cycle later, or 2 cycles later with the checksum enabled (CSUM beat accepted immediately).
- busy falls the cycle after DONE.
- err path: start → done/err pulse 1 cycle later.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - A running XOR of every handshaken data beat is kept and cleared on start.
  - After the last register beat, CSUM presents one extra beat: out_data=XOR, out_idx=0, out_last=1, same valid/ready rules.
  - The register beats carry out_last=0.
- REGDUMP_CHECKSUM_EN undefined: no CSUM state, no accumulator; out_last marks the final register beat.

## Structure
- regdump_pkg holds:
  - state enum
  - DATA_W/ADDR_W default constants
- Sub-module regdump_csum, compiled only under the macro: XOR accumulator with clear/enable inputs.
- The top-level FSM, index counter and output registers live in regfile_dumper.

## Test plan
- Registers hold x1=0x11111111, x2=0x22222222, x3=0x33333333; start with first=1, last=3, out_ready=1 → 3 beats (idx 1,2,3, data as loaded) on cycles 2/4/6; out_last on idx 3; done on cycle 7.
- Same dump with out_ready low for 5 cycles on beat 2 → data/idx held stable throughout; no beat lost or duplicated.
- first=5, last=2 → no out_valid; done=err=1 one cycle after start; busy back to 0 a cycle later.
- Abort during second SEND of range 0..31 → out_valid low next cycle, no done; a new start with 31..31 then yields a single beat with idx 31.
- With REGDUMP_CHECKSUM_EN, dump of x1..x3 above → 4th beat data 0x00000000 (0x11111111^0x22222222^0x33333333), idx 0, out_last=1.
- Reset asserted mid-dump → all outputs at their reset values next cycle; start accepted on the following cycle.
